// File: rtl/loader_pkg.sv
// Shared types for the boot-time memory image loader.
// Beat layout, loader states and the address classifier.
package loader_pkg;

  localparam logic [31:0] DEF_MEM_BASE  = 32'h0100_0000;
  localparam int          DEF_MEM_DEPTH = 65536;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } beat_t;

  typedef struct packed {
    logic mis;
    logic oor;
    logic ok;
  } addr_chk_t;

  // 33-bit compare so base + depth cannot wrap at 4 GiB
  function automatic addr_chk_t classify(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] depth
  );
    addr_chk_t   c;
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a     = {1'b0, addr};
    lo    = {1'b0, base};
    hi    = lo + depth;
    c.mis = (addr[1:0] != 2'b00);
    c.oor = (a < lo) || (a >= hi);
    c.ok  = !c.mis && !c.oor;
    return c;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams a 64-bit {data, addr} image into instruction/data memory,
// then releases the core from reset.
module mem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
  parameter int          MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int          AW        = $clog2(MEM_DEPTH / 4)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   MEM_tdata,
  input  logic          MEM_tvalid,
  input  logic          MEM_tlast,
  output logic          MEM_tready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          core_run,
  output logic [15:0]   word_count,
  output logic          err_align,
  output logic          err_range
);

  state_t      state;
  state_t      state_next;
  beat_t       beat;
  addr_chk_t   chk;
  logic        accept;
  logic [31:0] offset;

  assign beat   = beat_t'(MEM_tdata);
  assign chk    = classify(beat.addr, MEM_BASE, 33'(MEM_DEPTH));
  assign accept = MEM_tvalid && MEM_tready;
  assign offset = beat.addr - MEM_BASE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    MEM_tready = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        MEM_tready = 1'b1;
        if (MEM_tvalid) begin
          state_next = MEM_tlast ? FLUSH : LOAD;
        end
      end
      FLUSH: state_next = RUN;
      RUN:   state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept && chk.ok;
      if (accept && chk.ok) begin
        wr_addr <= AW'(offset >> 2);
        wr_data <= beat.data;
      end
    end
  end

  // Errors are sticky until the next reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_align <= 1'b0;
      err_range <= 1'b0;
    end else if (accept) begin
      err_align <= err_align | chk.mis;
      err_range <= err_range | chk.oor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
    end else if (wr_en && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_run <= 1'b0;
    end else begin
      core_run <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed and randomized image loads for mem_loader,
// checked against a transaction-level model of the loader.
module tb_mem_loader;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam longint      DEPTH = 65536;
  localparam int          AW    = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   MEM_tdata = '0;
  logic          MEM_tvalid = 1'b0;
  logic          MEM_tlast = 1'b0;
  logic          MEM_tready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_run;
  logic [15:0]   word_count;
  logic          err_align;
  logic          err_range;

  int checks = 0;
  int failures = 0;

  mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_tdata  (MEM_tdata),
    .MEM_tvalid (MEM_tvalid),
    .MEM_tlast  (MEM_tlast),
    .MEM_tready (MEM_tready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_run   (core_run),
    .word_count (word_count),
    .err_align  (err_align),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  // Reference model: image progress as counters/flags
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_count;
  bit          m_ea;
  bit          m_er;
  bit          m_done;
  int          m_done_cyc;
  int          cyc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_we));
    chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_addr));
    chk({tag, ".wr_data"}, 64'(wr_data), 64'(m_data));
    chk({tag, ".count"}, 64'(word_count), 64'(m_count));
    chk({tag, ".err_align"}, 64'(err_align), 64'(m_ea));
    chk({tag, ".err_range"}, 64'(err_range), 64'(m_er));
    chk({tag, ".core_run"},
        64'(core_run), 64'(m_done && (cyc > m_done_cyc)));
    chk({tag, ".run_vs_we"}, 64'(core_run && wr_en), 64'd0);
  endtask

  task automatic model_reset();
    m_we = 0; m_addr = '0; m_data = '0; m_count = 0;
    m_ea = 0; m_er = 0; m_done = 0; m_done_cyc = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    MEM_tvalid = 1'b0;
    MEM_tlast  = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".rst"});
    @(negedge clk);
    rst = 1'b1;
    chk({tag, ".rst_ready"}, 64'(MEM_tready), 64'd1);
  endtask

  // One clock: offer a beat (or none), then check the cycle after
  task automatic step(input bit v, input logic [31:0] a,
                      input logic [31:0] d, input bit l,
                      input string tag);
    bit     acc;
    bit     mis;
    bit     oor;
    longint la;
    MEM_tvalid = v;
    MEM_tdata  = {d, a};
    MEM_tlast  = l;
    #1;
    chk({tag, ".ready"}, 64'(MEM_tready), 64'(!m_done));
    acc = v && !m_done;
    @(posedge clk);
    #1;
    cyc++;
    if (m_we && m_count < 65535) m_count++;
    m_we = 0;
    if (acc) begin
      la  = longint'(a);
      mis = (a % 4) != 0;
      oor = (la < longint'(BASE)) || (la >= longint'(BASE) + DEPTH);
      m_ea = m_ea || mis;
      m_er = m_er || oor;
      if (!mis && !oor) begin
        m_we   = 1;
        m_addr = (a - BASE) / 4;
        m_data = d;
      end
      if (l) begin
        m_done     = 1;
        m_done_cyc = cyc;
      end
    end
    check_all(tag);
    MEM_tvalid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, tag);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8) return BASE + 4 * $urandom_range(0, 16383);
    if (sel == 8) return BASE + 4 * $urandom_range(0, 16383)
                         + $urandom_range(1, 3);
    if ($urandom_range(0, 1) == 0)
      return BASE - 4 * $urandom_range(1, 1000);
    return BASE + 32'(DEPTH) + 4 * $urandom_range(0, 1000);
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    do_reset("init");

    step(1, 32'h0100_0000, 32'hAAAA_0001, 0, "three0");
    step(1, 32'h0100_0004, 32'hAAAA_0002, 0, "three1");
    step(1, 32'h0100_0008, 32'hAAAA_0003, 1, "three2");
    idle(3, "three_tail");
    chk("three.count_final", 64'(word_count), 64'd3);
    chk("three.run_final", 64'(core_run), 64'd1);

    do_reset("mis");
    step(1, 32'h0100_0002, 32'h1234_5678, 1, "mis");
    idle(2, "mis_tail");
    chk("mis.flag", 64'({err_align, err_range}), 64'b10);

    do_reset("rng");
    step(1, 32'h00FF_FFFC, 32'h1111_1111, 0, "rng_lo");
    step(1, 32'h0101_0000, 32'h2222_2222, 1, "rng_hi");
    idle(2, "rng_tail");
    chk("rng.flag", 64'({err_align, err_range, word_count}),
        {46'd0, 2'b01, 16'd0});

    do_reset("one");
    step(1, 32'h0100_0000, 32'hCAFE_0000, 1, "one");
    for (int i = 0; i < 4; i++)
      step(1, BASE + 32'(4 * (i + 1)), 32'hDEAD_0000 + 32'(i), 0, "one_ign");
    chk("one.count_final", 64'(word_count), 64'd1);

    do_reset("mid");
    step(1, 32'h0100_0010, 32'h5555_0000, 0, "mid0");
    step(1, 32'h0100_0014, 32'h5555_0001, 0, "mid1");
    do_reset("mid_rst");
    for (int i = 0; i < 4; i++)
      step(1, BASE + 32'(4 * i), 32'h6666_0000 + 32'(i), i == 3, "reload");
    idle(2, "reload_tail");
    chk("reload.count_final", 64'(word_count), 64'd4);

    do_reset("gap");
    for (int i = 0; i < 5; i++) begin
      step(1, BASE + 32'(8 * i), 32'h7777_0000 + 32'(i), i == 4, "gap_beat");
      idle(2, "gap_idle");
    end

    step(1, BASE, 32'h0, 0, "dup_after_run");
    do_reset("dup");
    step(1, 32'h0100_0020, 32'h0000_0001, 0, "dup0");
    step(1, 32'h0100_0020, 32'h0000_0002, 1, "dup1");
    idle(2, "dup_tail");

    for (int img = 0; img < 3; img++) begin
      do_reset("rnd");
      for (int b = 0; b < 150; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1, "rnd_gap");
        step(1, rand_addr(), $urandom(), b == 149, "rnd");
      end
      idle(3, "rnd_tail");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter MEM_BASE, default 32'h01000000: byte address of word 0 of instruction/data memory.
REQ-002 Parameter MEM_DEPTH, default 65536: memory size in bytes, power of two, at least 8.
REQ-003 Parameter AW, default $clog2(MEM_DEPTH/4): width of the word address.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 MEM_tdata  in  64  beat payload: [63:32] data word, [31:0] byte address.
REQ-007 MEM_tvalid  in  1  beat valid.
REQ-008 MEM_tlast  in  1  final beat of the image.
REQ-009 MEM_tready  out  1  beat accepted when MEM_tvalid && MEM_tready.
REQ-010 wr_en  out  1  memory write strobe, one cycle per write.
REQ-011 wr_addr  out  AW  word address, (addr - MEM_BASE) >> 2.
REQ-012 wr_data  out  32  write data.
REQ-013 core_run  out  1  high releases the processor core from reset.
REQ-014 word_count  out  16  number of words written, saturating at 16'hFFFF.
REQ-015 err_align  out  1  sticky flag: a beat had addr[1:0] != 0.
REQ-016 err_range  out  1  sticky flag: a beat had an address outside [MEM_BASE, MEM_BASE+MEM_DEPTH).

Function
REQ-017 States: IDLE (no beat accepted), LOAD (image in progress), FLUSH (last write in flight), RUN (core released).
REQ-018 MEM_tready is 1 in IDLE and LOAD, and 0 in FLUSH and RUN.
REQ-019 Transitions on an accepted beat:
- IDLE -> LOAD if tlast = 0.
- IDLE -> FLUSH if tlast = 1.
- LOAD stays in LOAD if tlast = 0.
- LOAD -> FLUSH if tlast = 1.
REQ-020 FLUSH -> RUN unconditionally after one cycle.
REQ-021 RUN is terminal; only reset leaves RUN.
REQ-022 Valid beat (aligned and in range): wr_en = 1 exactly one cycle after acceptance, with that beat's registered wr_addr and wr_data; latency is 1.
REQ-023 Invalid beat: no write is issued; the corresponding error flag is set in the cycle after acceptance.
- Misaligned takes precedence over range in classification, but both flags may set on the same beat.
REQ-024 tlast on an invalid beat still ends the load (enters FLUSH).
REQ-025 Range check uses 33-bit arithmetic, so MEM_BASE + MEM_DEPTH does not wrap at 2^32.
REQ-026 Addresses below MEM_BASE are out of range.
REQ-027 word_count increments by 1 on each wr_en pulse and holds at 16'hFFFF.
REQ-028 core_run is registered and asserts in the first cycle of RUN, which is 2 cycles after the tlast beat is accepted.
- core_run is never high while wr_en is high.
REQ-029 Back-to-back valid beats, one per cycle, produce consecutive wr_en pulses with no bubbles.
REQ-030 A repeated address is written again (last write wins) and counted again.
REQ-031 MEM_tvalid in FLUSH or RUN is ignored: no write, no flag change.
REQ-032 wr_addr and wr_data hold their last value when wr_en = 0.

Reset
REQ-033 On rst = 0, asynchronously:
- state = IDLE, core_run = 0, wr_en = 0;
- wr_addr = 0, wr_data = 0, word_count = 0;
- err_align = 0, err_range = 0;
- MEM_tready = 1 once rst is released.
REQ-034 Reset asserted mid-load or in RUN discards all progress; no wr_en is issued in the cycle reset is released.

Structure
REQ-035 Package loader_pkg holds:
- the state enum (IDLE, LOAD, FLUSH, RUN);
- the default MEM_BASE and MEM_DEPTH constants;
- a packed struct for the 64-bit beat with fields data and addr.
REQ-036 Single module, no sub-module; the address classifier is a combinational function in loader_pkg.

Verification
REQ-037 Three valid beats (addresses 0x01000000, 0x01000004, 0x01000008; data 0xAAAA0001, 0xAAAA0002, 0xAAAA0003), tlast on the third beat:
- wr_addr 0, 1, 2 on consecutive cycles;
- word_count = 3;
- core_run rises 2 cycles after the third beat is accepted.
REQ-038 Beat with addr 0x01000002 -> no wr_en, err_align = 1, err_range = 0.
REQ-039 Beat with addr 0x00FFFFFC, then a beat with addr 0x01010000 (MEM_DEPTH = 65536) -> no writes, err_range = 1, word_count = 0.
REQ-040 Single beat with tlast at 0x01000000, followed by further tvalid beats:
- one write occurs;
- the state reaches RUN;
- MEM_tready = 0 thereafter;
- the later beats are ignored.
REQ-041 rst pulsed low after 2 of 4 beats -> all outputs at reset values immediately; a reload of 4 beats then yields word_count = 4.
REQ-042 Gaps in tvalid (1 beat every 3 cycles) -> wr_en pulses track the beats one-to-one, each 1 cycle after acceptance.
